// File: rtl/led_sequencer_arb_if.sv
// LED sequencer bus: CPU and AES status inputs, LED bank and status outputs.
interface led_sequencer_arb_if #(
    parameter int unsigned NUM_LEDS = 7
);
    logic                cpu_wr;
    logic [NUM_LEDS-1:0] cpu_pattern;
    logic                cpu_release;
    logic                aes_busy;
    logic                aes_done;
    logic                err;
    logic                err_clr;
    logic [NUM_LEDS-1:0] led;
    logic [1:0]          mode;
    logic                tick;

    modport master (
        output cpu_wr, cpu_pattern, cpu_release, aes_busy, aes_done, err, err_clr,
        input  led, mode, tick
    );

    modport slave (
        input  cpu_wr, cpu_pattern, cpu_release, aes_busy, aes_done, err, err_clr,
        output led, mode, tick
    );
endinterface

// File: rtl/led_sequencer_arb.sv
// LED bank owner: bouncing scan plus fixed-priority arbitration between
// error blink, AES-done flash, CPU pattern and the idle scan.
module led_sequencer_arb #(
    parameter int unsigned NUM_LEDS   = 7,
    parameter int unsigned TICK_DIV   = 12000000,
    parameter int unsigned HOLD_TICKS = 8
) (
    input logic                clk,
    input logic                rst,
    led_sequencer_arb_if.slave bus
);
    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned POS_W   = $clog2(NUM_LEDS);
    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);

    localparam logic [1:0] MODE_SCAN  = 2'd0;
    localparam logic [1:0] MODE_CPU   = 2'd1;
    localparam logic [1:0] MODE_EVENT = 2'd2;
    localparam logic [1:0] MODE_ERR   = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRESC_W-1:0]  prescaler_q, prescaler_d;
    logic                tick_q, tick_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic                slow_phase_q, slow_phase_d;
    logic                blink_phase_q, blink_phase_d;
    logic                cpu_own_q, cpu_own_d;
    logic [NUM_LEDS-1:0] cpu_reg_q, cpu_reg_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                err_lat_q, err_lat_d;
    logic [1:0]          mode_q, mode_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic                step_c;
    logic                presc_wrap_c;
    logic [POS_W-1:0]    pos_inc_c, pos_dec_c;
    logic [NUM_LEDS-1:0] err_pat_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler_q   <= '0;
            tick_q        <= 1'b0;
            pos_q         <= '0;
            dir_q         <= DIR_UP;
            slow_phase_q  <= 1'b0;
            blink_phase_q <= 1'b0;
            cpu_own_q     <= 1'b0;
            cpu_reg_q     <= '0;
            hold_cnt_q    <= '0;
            err_lat_q     <= 1'b0;
            mode_q        <= MODE_SCAN;
            led_q         <= NUM_LEDS'(1);
        end else begin
            prescaler_q   <= prescaler_d;
            tick_q        <= tick_d;
            pos_q         <= pos_d;
            dir_q         <= dir_d;
            slow_phase_q  <= slow_phase_d;
            blink_phase_q <= blink_phase_d;
            cpu_own_q     <= cpu_own_d;
            cpu_reg_q     <= cpu_reg_d;
            hold_cnt_q    <= hold_cnt_d;
            err_lat_q     <= err_lat_d;
            mode_q        <= mode_d;
            led_q         <= led_d;
        end
    end

    always_comb begin
        prescaler_d   = prescaler_q;
        tick_d        = 1'b0;
        pos_d         = pos_q;
        dir_d         = dir_q;
        slow_phase_d  = slow_phase_q;
        blink_phase_d = blink_phase_q;
        cpu_own_d     = cpu_own_q;
        cpu_reg_d     = cpu_reg_q;
        hold_cnt_d    = hold_cnt_q;
        err_lat_d     = err_lat_q;
        mode_d        = MODE_SCAN;
        led_d         = NUM_LEDS'(1) << pos_q;
        err_pat_c     = '0;

        presc_wrap_c = (prescaler_q == PRESC_W'(TICK_DIV - 1));
        prescaler_d  = presc_wrap_c ? '0 : prescaler_q + PRESC_W'(1);
        tick_d       = presc_wrap_c;

        // Half-speed scan when idle: only every other tick becomes a step.
        step_c = tick_q & (bus.aes_busy | slow_phase_q);
        if (tick_q) begin
            blink_phase_d = ~blink_phase_q;
            if (!bus.aes_busy) slow_phase_d = ~slow_phase_q;
        end

        pos_inc_c = pos_q + POS_W'(1);
        pos_dec_c = pos_q - POS_W'(1);
        if (step_c) begin
            case (dir_q)
                DIR_UP: begin
                    pos_d = pos_inc_c;
                    if (pos_inc_c == POS_W'(NUM_LEDS - 1)) dir_d = DIR_DOWN;
                end
                DIR_DOWN: begin
                    pos_d = pos_dec_c;
                    if (pos_dec_c == '0) dir_d = DIR_UP;
                end
                default: dir_d = DIR_UP;
            endcase
        end

        err_lat_d = bus.err | (err_lat_q & ~bus.err_clr);

        if (bus.aes_done) begin
            hold_cnt_d = HOLD_W'(HOLD_TICKS);
        end else if (tick_q && (hold_cnt_q != '0)) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end

        if (bus.cpu_wr) begin
            cpu_reg_d = bus.cpu_pattern;
            cpu_own_d = 1'b1;
        end else if (bus.cpu_release) begin
            cpu_own_d = 1'b0;
        end

        // Even bits lit on blink_phase=1, odd bits otherwise.
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            err_pat_c[i] = blink_phase_q ^ i[0];
        end

        if (err_lat_q) begin
            mode_d = MODE_ERR;
            led_d  = err_pat_c;
        end else if (hold_cnt_q != '0) begin
            mode_d = MODE_EVENT;
            led_d  = '1;
        end else if (cpu_own_q) begin
            mode_d = MODE_CPU;
            led_d  = cpu_reg_q;
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_sequencer_arb.sv
// Bench for led_sequencer_arb: directed scenarios then random traffic,
// compared cycle by cycle against an arithmetic reference model.
module tb_led_sequencer_arb;
    localparam int unsigned NUM_LEDS   = 7;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned HOLD_TICKS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_sequencer_arb_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_sequencer_arb #(
        .NUM_LEDS  (NUM_LEDS),
        .TICK_DIV  (TICK_DIV),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state: counts of events since reset, not flop images.
    bit                  valid = 0;
    int                  cyc_n;
    bit                  tick_m;
    int                  ticks_m;
    int                  idle_ticks_m;
    int                  steps_m;
    int                  hold_m;
    bit                  err_m;
    bit                  cpu_on_m;
    logic [NUM_LEDS-1:0] cpu_pat_m;
    logic [NUM_LEDS-1:0] exp_led;
    logic [1:0]          exp_mode;

    function automatic logic [NUM_LEDS-1:0] scan_led(input int k);
        int p;
        p = k % (2 * NUM_LEDS - 2);
        if (p >= NUM_LEDS) p = 2 * NUM_LEDS - 2 - p;
        return NUM_LEDS'(1) << p;
    endfunction

    function automatic logic [NUM_LEDS-1:0] err_led(input int t);
        logic [NUM_LEDS-1:0] even;
        even = '0;
        for (int i = 0; i < NUM_LEDS; i += 2) even[i] = 1'b1;
        return (t % 2 == 1) ? even : ~even;
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            valid        = 1;
            cyc_n        = 0;
            tick_m       = 0;
            ticks_m      = 0;
            idle_ticks_m = 0;
            steps_m      = 0;
            hold_m       = 0;
            err_m        = 0;
            cpu_on_m     = 0;
            cpu_pat_m    = '0;
            exp_led      = NUM_LEDS'(1);
            exp_mode     = 2'd0;
        end else if (valid) begin
            if (err_m) begin
                exp_mode = 2'd3; exp_led = err_led(ticks_m);
            end else if (hold_m != 0) begin
                exp_mode = 2'd2; exp_led = '1;
            end else if (cpu_on_m) begin
                exp_mode = 2'd1; exp_led = cpu_pat_m;
            end else begin
                exp_mode = 2'd0; exp_led = scan_led(steps_m);
            end
            if (tick_m) begin
                if (bus.aes_busy || (idle_ticks_m % 2 == 1)) steps_m++;
                if (!bus.aes_busy) idle_ticks_m++;
                ticks_m++;
            end
            if (bus.aes_done) hold_m = HOLD_TICKS;
            else if (tick_m && hold_m > 0) hold_m--;
            if (bus.err) err_m = 1;
            else if (bus.err_clr) err_m = 0;
            if (bus.cpu_wr) begin
                cpu_pat_m = bus.cpu_pattern;
                cpu_on_m  = 1;
            end else if (bus.cpu_release) begin
                cpu_on_m = 0;
            end
            cyc_n++;
            tick_m = (cyc_n % TICK_DIV == 0);
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check_eq("led", 32'(bus.led), 32'(exp_led));
            check_eq("mode", 32'(bus.mode), 32'(exp_mode));
            check_eq("tick", 32'(bus.tick), 32'(tick_m));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_pulses();
        bus.cpu_wr      = 1'b0;
        bus.cpu_release = 1'b0;
        bus.aes_done    = 1'b0;
        bus.err         = 1'b0;
        bus.err_clr     = 1'b0;
    endtask

    initial begin
        clear_pulses();
        bus.cpu_pattern = '0;
        bus.aes_busy    = 1'b0;
        rst             = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(110);

        bus.aes_busy = 1'b1; cyc(40);
        bus.aes_busy = 1'b0; cyc(40);

        bus.cpu_wr = 1'b1; bus.cpu_pattern = 7'b0110011; cyc(1);
        clear_pulses(); cyc(20);
        bus.cpu_release = 1'b1; cyc(1);
        clear_pulses(); cyc(20);
        bus.cpu_wr = 1'b1; bus.cpu_release = 1'b1; bus.cpu_pattern = 7'b1000001; cyc(1);
        clear_pulses(); cyc(5);

        bus.aes_done = 1'b1; cyc(1);
        clear_pulses(); cyc(20);
        bus.aes_done = 1'b1; cyc(1);
        clear_pulses(); cyc(40);

        bus.err = 1'b1; cyc(1);
        clear_pulses(); cyc(12);
        bus.err = 1'b1; bus.err_clr = 1'b1; cyc(1);
        clear_pulses(); cyc(5);
        bus.err_clr = 1'b1; cyc(1);
        clear_pulses(); cyc(5);

        bus.err = 1'b1; cyc(1);
        clear_pulses(); bus.aes_done = 1'b1; cyc(1);
        clear_pulses(); cyc(3);
        rst = 1'b0; cyc(1);
        rst = 1'b1; cyc(12);

        for (int i = 0; i < 3000; i++) begin
            bus.cpu_wr      = ($urandom_range(0, 19) == 0);
            bus.cpu_release = ($urandom_range(0, 19) == 0);
            bus.cpu_pattern = NUM_LEDS'($urandom);
            bus.aes_done    = ($urandom_range(0, 39) == 0);
            bus.err         = ($urandom_range(0, 79) == 0);
            bus.err_clr     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) bus.aes_busy = ~bus.aes_busy;
            rst = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        clear_pulses();
        rst = 1'b1;
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
